sync_tx_sched: RTL and testbench
================================

Name: sync_tx_sched

Overview:
- Round-robin scheduler that shares the TX half of the toggle-handshake data synchroniser between NREQ local requesters.
- Accepts one word at a time from a requester using a valid/ack handshake.
- Presents the word and the source tag as stable asynchronous data, toggles the request line, and waits for the resynchronised acknowledgement toggle before accepting the next word.
- Sits in the source clock domain. Drives the data_a/tx_a inputs of the RX half and receives its rx toggle.

Parameters:
- WIDTH, 8, data word width in bits
- NREQ, 4, number of requesters (2..16)
- TAGW, 2, tag width; must be at least clog2(NREQ)
- TIMEOUT, 1023, WAIT-state cycle limit before err is set (0 disables the check)

Ports:
- clk  in  1  domain clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous and active-low
- req  in  NREQ  per-requester word-valid level
- data_in  in  NREQ*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-hot pulse; the word of the acked requester is captured at this edge
- data_a  out  WIDTH  registered word towards the RX half; stable for the whole transfer
- tag_a  out  TAGW  registered index of the source requester; stable with data_a
- tx_a  out  1  toggling handshake request
- rx_a  in  1  toggling acknowledgement from the RX half (asynchronous)
- busy  out  1  high whenever state is not IDLE
- err  out  1  sticky; set on WAIT timeout

Behaviour:
- Reset (async assert, sync release via rst_n): state=IDLE, tx_a=0, data_a=0, tag_a=0, ack=0, busy=0, err=0, rr pointer=0, both rx sync flops=0, timeout counter=0.
- rx_a passes through two FD-style flops to give rx_s. No other logic reads rx_a.
- IDLE:
  - If req is nonzero, the grant g is the first set bit searching upward from ptr and wrapping modulo NREQ.
  - ack[g]=1 combinationally in that cycle.
  - At the edge: data_a<=data_in[g], tag_a<=g, ptr<=(g+1) mod NREQ, go to SETUP.
  - If req is zero: ack=0 and the block stays in IDLE.
- SETUP: one cycle holding data_a steady before the request edge. At the edge: tx_a<=~tx_a, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - When rx_s==tx_a: go to IDLE, counter<=0.
  - If the counter reaches TIMEOUT (and TIMEOUT!=0): err<=1, stay in WAIT. The transfer is never aborted, because the toggle protocol cannot be rolled back.
- data_a and tag_a change only at the IDLE->SETUP edge, never while tx_a!=rx_s.
- Throughput: at most one word per (3 + ack round trip) cycles. Minimum loop with a same-clock RX half is about 8 cycles from ack to the next possible ack.
- Requester contract: a requester holds req and data_in until it sees ack. If req is still high in a later IDLE cycle, that is a new word.
- Deasserting req before ack is allowed; the word is simply not sent.
- Simultaneous requests: exactly one ack per IDLE cycle. Round-robin order guarantees each requester waits at most NREQ-1 transfers.
- A requester that was just served wins the next IDLE cycle only if no other req is high.
- A req bit that rises during SETUP or WAIT has no effect until IDLE.
- Reset mid-transfer returns tx_a to 0. The RX half must be reset in the same reset event; this block does not re-align the toggle parity.
- err clears only on reset.

Decomposition:
- Shared package/header: the state encoding constants (IDLE, SETUP, WAIT) and the TAGW derivation helper (clog2).
- One sub-module, rr_arbiter:
  - inputs: req[NREQ], ptr
  - outputs: one-hot grant and encoded index
  - purely combinational
- The FSM, sync flops, pointer and timeout counter stay in sync_tx_sched.

Test Plan:
- Reset with req=4'b1111 held: all outputs 0 during reset; after release the first ack is 4'b0001, with data_a=data_in[0] and tag_a=0 one edge later.
- Single requester 2 with data 8'hA5, RX half on the same clk: ack[2] pulses once; tx_a toggles 0->1 two edges after ack; busy drops after rx_s==1; RX out=8'hA5.
- req=4'b1111 held continuously for 8 words: ack order is 0,1,2,3,0,1,2,3, and tag_a matches each word; no ack occurs while busy=1.
- Requester 1 raises req during WAIT while requester 3 is served with ptr=0: the next grant is 1; tx_a and data_a do not change during WAIT.
- TIMEOUT=15 with rx_a tied low after a toggle: err=1 after 15 WAIT cycles and the block stays busy. Releasing rx_a=1 returns it to IDLE with err still 1.
- rst_n asserted mid-WAIT with tx_a=1: tx_a, busy and ptr clear immediately (asynchronously); the next transfer starts from requester 0.

Source files
------------

// File: rtl/sync_tx_sched_pkg.sv
// rtl/sync_tx_sched_pkg.sv - shared state encoding and width helper for sync_tx_sched
package sync_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/sync_tx_sched_rr_arbiter.sv
// rtl/sync_tx_sched_rr_arbiter.sv - combinational round-robin grant starting at ptr
module sync_tx_sched_rr_arbiter
    import sync_tx_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [TAGW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [TAGW-1:0] idx
);

    always_comb begin
        int best_d;
        int best_i;
        int d;
        best_d = NREQ;
        best_i = 0;
        d      = 0;
        // Distance from ptr, wrapping, picks the first set bit at or above ptr.
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + NREQ;
            if (req[i] && (d < best_d)) begin
                best_d = d;
                best_i = i;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = (best_d < NREQ) && (i == best_i);
        end
        idx = TAGW'(best_i);
    end

endmodule

// File: rtl/sync_tx_sched.sv
// rtl/sync_tx_sched.sv - round-robin scheduler feeding the TX side of a toggle-handshake synchroniser
module sync_tx_sched
    import sync_tx_sched_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TAGW    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      data_a,
    output logic [TAGW-1:0]       tag_a,
    output logic                  tx_a,
    input  logic                  rx_a,
    output logic                  busy,
    output logic                  err
);

    localparam int CNTW = (TIMEOUT < 2) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] TMAX = CNTW'(TIMEOUT);

    state_t            state;
    logic [TAGW-1:0]   ptr;
    logic              rx_meta;
    logic              rx_s;
    logic [CNTW-1:0]   cnt;
    logic [NREQ-1:0]   grant;
    logic [TAGW-1:0]   gidx;
    logic [WIDTH-1:0]  sel_data;

    sync_tx_sched_rr_arbiter #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == TAGW'(i)) sel_data = data_in[i*WIDTH +: WIDTH];
        end
    end

    // ack is gated by reset so nothing is offered to requesters while held in reset.
    assign ack  = (rst_n && (state == ST_IDLE)) ? grant : '0;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_a    <= 1'b0;
            data_a  <= '0;
            tag_a   <= '0;
            ptr     <= '0;
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            rx_meta <= rx_a;
            rx_s    <= rx_meta;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        data_a <= sel_data;
                        tag_a  <= gidx;
                        ptr    <= (gidx == TAGW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    tx_a  <= ~tx_a;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rx_s == tx_a) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        // The toggle cannot be withdrawn, so a timeout only flags.
                        if (cnt != TMAX) cnt <= cnt + 1'b1;
                        if ((TIMEOUT != 0) && (cnt == TMAX - 1'b1)) err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_tx_sched.sv
// tb/tb_sync_tx_sched.sv - randomized self-checking bench for sync_tx_sched
module tb_sync_tx_sched;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TAGW    = 2;
    localparam int TIMEOUT = 15;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      data_a;
    logic [TAGW-1:0]       tag_a;
    logic                  tx_a;
    logic                  rx_a;
    logic                  busy;
    logic                  err;

    int tests_run    = 0;
    int tests_failed = 0;
    int m_ptr        = 0;
    logic [9:0] exp_q[$];
    logic [9:0] rx_q[$];
    int gnt_log[$];

    logic s1, s2;
    bit   hold_rx;

    sync_tx_sched #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TAGW    (TAGW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .ack     (ack),
        .data_a  (data_a),
        .tag_a   (tag_a),
        .tx_a    (tx_a),
        .rx_a    (rx_a),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Same-clock RX half: resynchronise tx_a, capture the word, return the toggle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            rx_a <= 1'b0;
        end else begin
            s1 <= tx_a;
            s2 <= s1;
            if (!hold_rx && (s2 != rx_a)) begin
                rx_a <= s2;
                rx_q.push_back({tag_a, data_a});
            end
        end
    end

    function automatic int model_grant(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        hold_rx = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        rx_q.delete();
        m_ptr = 0;
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] d0;
        bit ok;
        rst_n = 1'b0;
        hold_rx = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = 8'($urandom);
        d0 = data_in[7:0];
        @(negedge clk);
        if ({ack, tx_a, data_a, tag_a, busy, err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got ack=%b tx=%b data=%h tag=%0d busy=%b err=%b want all 0", ack, tx_a, data_a, tag_a, busy, err);
        end
        tests_run++;
        rst_n = 1'b1;
        #1;
        if (ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_ack got %b want 0001", ack);
        end
        tests_run++;
        @(posedge clk);
        #1;
        if ({tag_a, data_a, busy} !== {2'd0, d0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_first_capture got tag=%0d data=%h busy=%b want tag=0 data=%h busy=1", tag_a, data_a, busy, d0);
        end
        tests_run++;
        req = '0;
        wait_idle(50, ok);
        if (!ok || rx_q.size() != 1 || rx_q[0] !== {2'd0, d0}) begin
            tests_failed++;
            $display("FAIL reset_first_delivery got ok=%b n=%0d want one word %h", ok, rx_q.size(), {2'd0, d0});
        end
        tests_run++;
    endtask

    task automatic test_single();
        int extra;
        bit ok;
        do_reset();
        data_in[23:16] = 8'hA5;
        req = 4'b0100;
        @(negedge clk);
        if (ack !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_ack got %b want 0100", ack);
        end
        tests_run++;
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        if (tx_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_tx_setup got %b want 0", tx_a);
        end
        tests_run++;
        @(negedge clk);
        if (tx_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_tx_toggle got %b want 1", tx_a);
        end
        tests_run++;
        extra = 0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ack !== '0) extra++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok || extra != 0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_complete got idle=%b extra_acks=%0d err=%b want 1 0 0", ok, extra, err);
        end
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== {2'd2, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single_rx_word got n=%0d want one word %h", rx_q.size(), {2'd2, 8'hA5});
        end
        tests_run++;
    endtask

    task automatic run_traffic(input int nwords, input bit all_on, input int max_cycles);
        int acks;
        int cyc;
        int g;
        int exp_g;
        logic [3:0] exp_ack;
        logic [9:0] last;
        bit have_last;
        gnt_log.delete();
        exp_q.delete();
        rx_q.delete();
        acks = 0;
        cyc = 0;
        have_last = 1'b0;
        last = '0;
        req = '0;
        while (cyc < max_cycles) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!all_on && req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
                if (!req[i] && (acks + $countones(req)) < nwords &&
                    (all_on || $urandom_range(0, 2) == 0)) begin
                    data_in[i*WIDTH +: WIDTH] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            exp_g = model_grant(req, m_ptr);
            exp_ack = (busy || exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
            if (ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL rr_ack got %b want %b (busy=%b req=%b)", ack, exp_ack, busy, req);
            end
            tests_run++;
            if (busy && have_last) begin
                if ({tag_a, data_a} !== last) begin
                    tests_failed++;
                    $display("FAIL rr_hold got %h want %h", {tag_a, data_a}, last);
                end
                tests_run++;
            end
            if (acks == nwords && !busy) break;
            g = -1;
            if (!busy && exp_g >= 0) begin
                g = exp_g;
                last = {2'(g), data_in[g*WIDTH +: WIDTH]};
                have_last = 1'b1;
                exp_q.push_back(last);
                gnt_log.push_back(g);
                m_ptr = (g + 1) % NREQ;
                acks++;
            end
            @(posedge clk);
            #1;
            if (g >= 0) req[g] = 1'b0;
        end
        if (cyc >= max_cycles) begin
            tests_failed++;
            $display("FAIL rr_timeout got %0d words want %0d", acks, nwords);
        end
        tests_run++;
        if (rx_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rr_rx_count got %0d want %0d", rx_q.size(), exp_q.size());
        end
        tests_run++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rr_rx_word[%0d] got %h want %h", i, rx_q[i], exp_q[i]);
            end
            tests_run++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        run_traffic(8, 1'b1, 400);
        if (gnt_log.size() != 8) begin
            tests_failed++;
            $display("FAIL rr_order_len got %0d want 8", gnt_log.size());
        end
        tests_run++;
        for (int i = 0; i < gnt_log.size(); i++) begin
            if (gnt_log[i] != i % 4) begin
                tests_failed++;
                $display("FAIL rr_order[%0d] got %0d want %0d", i, gnt_log[i], i % 4);
            end
            tests_run++;
        end
    endtask

    task automatic test_random();
        do_reset();
        run_traffic(40, 1'b0, 3000);
    endtask

    task automatic test_late_req();
        logic [7:0] d3;
        logic [7:0] d1;
        bit ok;
        do_reset();
        d3 = 8'($urandom);
        d1 = 8'($urandom);
        data_in[31:24] = d3;
        data_in[15:8]  = d1;
        req = 4'b1000;
        @(negedge clk);
        if (ack !== 4'b1000) begin
            tests_failed++;
            $display("FAIL late_first_ack got %b want 1000", ack);
        end
        tests_run++;
        @(posedge clk);
        #1 req = '0;
        repeat (2) @(negedge clk);
        req[1] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if ({ack, tx_a, data_a} !== {4'b0000, 1'b1, d3}) begin
                tests_failed++;
                $display("FAIL late_wait_stable got ack=%b tx=%b data=%h want 0000 1 %h", ack, tx_a, data_a, d3);
            end
            tests_run++;
        end
        if (!ok || ack !== 4'b0010) begin
            tests_failed++;
            $display("FAIL late_next_grant got idle=%b ack=%b want 1 0010", ok, ack);
        end
        tests_run++;
        @(posedge clk);
        #1 req = '0;
        wait_idle(50, ok);
        if (!ok || rx_q.size() != 2 || rx_q[0] !== {2'd3, d3} || rx_q[1] !== {2'd1, d1}) begin
            tests_failed++;
            $display("FAIL late_rx_words got idle=%b n=%0d want %h then %h", ok, rx_q.size(), {2'd3, d3}, {2'd1, d1});
        end
        tests_run++;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        hold_rx = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        @(posedge clk);
        #1 req = '0;
        repeat (2) @(negedge clk);
        if (tx_a !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_enter got tx=%b err=%b want 1 0", tx_a, err);
        end
        tests_run++;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 14 && err !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_early got err=%b want 0 after 14 cycles", err);
            end
            if (k == 14) tests_run++;
        end
        if (err !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_err got err=%b busy=%b want 1 1", err, busy);
        end
        tests_run++;
        repeat (5) @(negedge clk);
        if (err !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_hold got err=%b busy=%b want 1 1", err, busy);
        end
        tests_run++;
        hold_rx = 1'b0;
        wait_idle(20, ok);
        if (!ok || err !== 1'b1 || rx_q.size() != 1) begin
            tests_failed++;
            $display("FAIL timeout_release got idle=%b err=%b n=%0d want 1 1 1", ok, err, rx_q.size());
        end
        tests_run++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d0;
        bit ok;
        do_reset();
        hold_rx = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        @(posedge clk);
        #1 req = '0;
        repeat (3) @(negedge clk);
        if (tx_a !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre got tx=%b busy=%b want 1 1", tx_a, busy);
        end
        tests_run++;
        #1 rst_n = 1'b0;
        #1;
        if ({tx_a, busy, ack} !== 6'b0) begin
            tests_failed++;
            $display("FAIL mid_async_clear got tx=%b busy=%b ack=%b want 0 0 0000", tx_a, busy, ack);
        end
        tests_run++;
        hold_rx = 1'b0;
        rx_q.delete();
        for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = 8'($urandom);
        d0 = data_in[7:0];
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        #1;
        if (ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_restart_ack got %b want 0001", ack);
        end
        tests_run++;
        @(posedge clk);
        #1 req = '0;
        wait_idle(50, ok);
        if (!ok || rx_q.size() != 1 || rx_q[0] !== {2'd0, d0}) begin
            tests_failed++;
            $display("FAIL mid_restart_word got idle=%b n=%0d want %h", ok, rx_q.size(), {2'd0, d0});
        end
        tests_run++;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        data_in = '0;
        hold_rx = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_late_req();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
